// File: rtl/display_scanner.sv
// Binary-to-BCD front end and four-digit multiplexer for a common-anode seven-segment display.
// Anode enables trail the digit code by one cycle to line up with the downstream decoder's registered segments.
module display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  number,
  output logic [3:0]  anode
);

  localparam int unsigned    PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [13:0]    MAX_VALUE  = 14'd9999;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [13:0]   shift_q,   shift_d;
  logic [15:0]   bcd_q,     bcd_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          ovf_q,     ovf_d;
  logic [15:0]   digits_q,  digits_d;
  logic [3:0]    blank_q,   blank_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [1:0]    idx_q,     idx_d;
  logic [3:0]    number_q,  number_d;
  logic [3:0]    anode_q,   anode_d;
  logic          live_q;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A digit is blanked only when it and every more significant digit are zero.
  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

  // NOTE: every variable assigned here gets its current-state default first, so no latch is inferred.
  always_comb begin
    logic [15:0] adj;
    adj       = add3(bcd_q);
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    ovf_d     = ovf_q;
    digits_d  = digits_q;
    blank_d   = blank_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d   = (value > MAX_VALUE) ? MAX_VALUE : value;
          ovf_d     = (value > MAX_VALUE);
          bcd_d     = 16'd0;
          bit_cnt_d = 4'd0;
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {bcd_d, shift_d} = {adj, shift_q} << 1;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd13) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        digits_d = bcd_q;
        blank_d  = BLANK_LZ ? lz_mask(bcd_q) : 4'b0000;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running scan; number picks up a fresh commit in the same cycle it lands.
  always_comb begin
    presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    idx_d    = (presc_q == PRESC_LAST) ? idx_q + 2'd1 : idx_q;
    number_d = digits_d[{idx_d, 2'b00} +: 4];
    anode_d  = (!live_q || blank_q[idx_q]) ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      ovf_q     <= 1'b0;
      digits_q  <= '0;
      blank_q   <= {{3{BLANK_LZ}}, 1'b0};
      presc_q   <= '0;
      idx_q     <= '0;
      number_q  <= '0;
      anode_q   <= 4'b1111;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      ovf_q     <= ovf_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      number_q  <= number_d;
      anode_q   <= anode_d;
      live_q    <= 1'b1;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign overflow = ovf_q;
  assign number   = number_q;
  assign anode    = anode_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: loads push expected BCD/blank/overflow, a monitor pops them on
// each conversion completion and checks every scan cycle against a timing model of the multiplexer.
module tb_display_scanner;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic        busy, overflow;
  logic [3:0]  number, anode;
  logic        busy_nb, overflow_nb;
  logic [3:0]  number_nb, anode_nb;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy), .overflow(overflow), .number(number), .anode(anode)
  );

  display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy_nb), .overflow(overflow_nb), .number(number_nb), .anode(anode_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the scan timing, advanced once per rising edge and sampled on the falling edge.
  logic [1:0]  m_presc, m_idx;
  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_anode;
  logic        m_live, busy_prev;
  int          t_run;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_busy", busy, 0);
        check("rst_anode", anode, 4'hf);
        check("rst_number", number, 0);
        m_presc = 2'd0; m_idx = 2'd0; m_digits = 16'h0000; m_blank = 4'b1110;
        m_live = 1'b0; busy_prev = 1'b0; t_run = -1;
      end else begin
        m_anode = (!m_live || m_blank[m_idx]) ? 4'hf : ~(4'b0001 << m_idx);
        m_live  = 1'b1;
        if (m_presc == 2'd3) begin
          m_presc = 2'd0;
          m_idx   = m_idx + 2'd1;
        end else begin
          m_presc = m_presc + 2'd1;
        end
        if (load && !busy_prev) begin
          check("busy_rise", busy, 1);
          t_run = 0;
        end else if (t_run >= 0) begin
          t_run++;
        end
        if (busy_prev && !busy) begin
          check("busy_len", t_run, 15);
          if (sb.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL sb_empty: got a completed conversion, expected none (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            check("overflow", overflow, e.ovf);
            m_digits = e.bcd;
            m_blank  = e.blank;
          end
          t_run = -1;
        end
        busy_prev = busy;
        check("number", number, m_digits[{m_idx, 2'b00} +: 4]);
        check("anode", anode, m_anode);
        check("anode_onecold", $countones(~anode) <= 1, 1);
      end
    end
  end

  task automatic do_load(input logic [13:0] v, input logic [15:0] bcd, input logic [3:0] blank,
                         input logic ovf, input bit accepted);
    exp_t x;
    x = '{bcd: bcd, blank: blank, ovf: ovf};
    @(negedge clk); #1;
    value = v;
    load  = 1'b1;
    if (accepted) sb.push_back(x);
    @(negedge clk); #1;
    load = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  run, wraps;
    bit  seen;
    logic [3:0] prev;

    rst_n = 1'b0; load = 1'b0; value = '0;
    settle(3); #1 rst_n = 1'b1;
    settle(20);

    // Reset in the middle of a conversion clears outputs without a clock edge.
    do_load(14'd1234, 16'h1234, 4'b0000, 1'b0, 1'b1);
    settle(5);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_anode", anode, 4'hf);
    check("async_number", number, 0);
    sb.delete();
    settle(2); #1 rst_n = 1'b1;
    settle(24);

    do_load(14'd1234,  16'h1234, 4'b0000, 1'b0, 1'b1); settle(40);
    do_load(14'd12000, 16'h9999, 4'b0000, 1'b1, 1'b1); settle(40);
    do_load(14'd42,    16'h0042, 4'b1100, 1'b0, 1'b1); settle(40);
    do_load(14'd1005,  16'h1005, 4'b0000, 1'b0, 1'b1); settle(1);
    do_load(14'd7,     16'h0007, 4'b1110, 1'b0, 1'b0); settle(40);
    do_load(14'd9999,  16'h9999, 4'b0000, 1'b0, 1'b1); settle(40);
    do_load(14'd0,     16'h0000, 4'b1110, 1'b0, 1'b1); settle(40);

    // Without blanking, value 0 lights every slot for exactly four cycles in 0,1,2,3,0 order.
    run = 0; wraps = 0; seen = 1'b0;
    @(negedge clk);
    prev = anode_nb;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("nb_number", number_nb, 0);
      check("nb_onecold", $countones(~anode_nb), 1);
      if (anode_nb != prev) begin
        if (seen) check("nb_slot_len", run, 4);
        check("nb_order", anode_nb, {prev[2:0], prev[3]});
        if (prev == 4'b0111) wraps++;
        seen = 1'b1;
        run  = 1;
      end else begin
        run++;
      end
      prev = anode_nb;
    end
    check("nb_wrap_seen", wraps >= 1, 1);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
